hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage pipeline. It drives PC write-enable, the IF/ID hold and flush controls, the ID/EX bubble and the global pipeline freeze.
- Resolves three hazard classes:
  - load-use hazards from ID/EX;
  - taken branches and jumps resolved in ID;
  - multi-cycle data-memory accesses from MEM, via a req/ack handshake.
- Also keeps saturating stall/flush performance counters and a memory-timeout error flag.

---
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Handles load-use stalls, ID-resolved redirects and multi-cycle data-memory
// waits, and keeps saturating stall/flush counters plus a sticky timeout flag.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RegRt_i,
    input  logic [4:0]       IFID_RegRs_i,
    input  logic [4:0]       IFID_RegRt_i,
    input  logic             Branch_taken_i,
    input  logic             Jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             Flush_o,
    output logic             IDEX_Bubble_o,
    output logic             Freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_err_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // wait_cnt only has to reach MEM_TIMEOUT-1, where it parks.
    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t          state, state_nxt;
    logic            pend_flush, pend_nxt;
    logic [WC_W-1:0] wait_cnt;

    logic lu, lu_eff, redirect, miss, frozen;

    assign lu       = IDEX_MemRead_i && (IDEX_RegRt_i != 5'd0) &&
                      ((IDEX_RegRt_i == IFID_RegRs_i) || (IDEX_RegRt_i == IFID_RegRt_i));
    assign redirect = Branch_taken_i | Jump_i;
    assign miss     = dmem_req_i & ~dmem_ack_i;

    // The bubble from a load-use stall is already in EX during LU_STALL, so a
    // still-matching lu there is stale and must not stall again.
    assign lu_eff   = lu && (state != LU_STALL);
    // In MEM_WAIT only the ack releases the freeze; elsewhere a new miss starts one.
    assign frozen   = (state == MEM_WAIT) ? ~dmem_ack_i : miss;

    // State register and pending-flush memory.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state      <= RUN;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nxt;
            pend_flush <= pend_nxt;
        end
    end

    // Next-state logic; a redirect seen while entering a miss is parked in
    // pend_flush and consumed on the first cycle that actually flushes.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_flush;
        if (state == MEM_WAIT) begin
            if (dmem_ack_i) begin
                state_nxt = RUN;
                if (!lu) begin
                    pend_nxt = 1'b0;
                end
            end
        end else begin
            if (miss) begin
                state_nxt = MEM_WAIT;
                if (redirect) begin
                    pend_nxt = 1'b1;
                end
            end else if (lu_eff) begin
                state_nxt = LU_STALL;
            end else begin
                state_nxt = RUN;
                pend_nxt  = 1'b0;
            end
        end
    end

    // Mealy outputs with priority freeze > load-use stall > flush > normal;
    // everything is held low while reset is asserted.
    always_comb begin
        PCWrite_o     = 1'b0;
        IFIDWrite_o   = 1'b0;
        Flush_o       = 1'b0;
        IDEX_Bubble_o = 1'b0;
        Freeze_o      = 1'b0;
        if (start_i) begin
            if (frozen) begin
                Freeze_o    = 1'b1;
                IFIDWrite_o = 1'b1;
            end else if (lu_eff) begin
                IFIDWrite_o   = 1'b1;
                IDEX_Bubble_o = 1'b1;
            end else if (redirect || pend_flush) begin
                Flush_o   = 1'b1;
                PCWrite_o = 1'b1;
            end else begin
                PCWrite_o = 1'b1;
            end
        end
    end

    // Memory wait counter and sticky timeout flag; waiting continues after timeout.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            wait_cnt  <= '0;
            mem_err_o <= 1'b0;
        end else if ((state == MEM_WAIT) && !dmem_ack_i) begin
            if (wait_cnt == WAIT_LAST) begin
                mem_err_o <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + WC_W'(1);
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Saturating performance counters for stalled and flushed cycles.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (!PCWrite_o && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (Flush_o && (flush_cnt_o != CNT_MAX)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule
